// File: rtl/cache_controller_if.sv
// ---------------------------------------------------------------------------
// cache_controller_if : MEM-stage and SRAM-controller bus bundle for the cache
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cache_controller_if;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_write_en;
  logic        sram_read_en;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  // The cache controller: serves the MEM stage, initiates SRAM requests.
  modport slave (
    input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
    output rdata, ready, sram_address, sram_wdata, sram_write_en, sram_read_en
  );

  // The surrounding environment: MEM stage plus SRAM controller.
  modport master (
    output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
    input  rdata, ready, sram_address, sram_wdata, sram_write_en, sram_read_en
  );
endinterface

`default_nettype wire

// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller : 2-way set-associative write-through read cache (LRU)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  cache_controller_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL0 = 3'd1,
    FILL1 = 3'd2,
    WRITE = 3'd3,
    WDONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0][SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]       lru_q, lru_d;
  logic                  read_en_q, read_en_d;
  logic                  write_en_q, write_en_d;

  logic [31:0]           data_mem [0:1][0:SETS-1][0:1];
  logic [TAG_W-1:0]      tag_mem  [0:1][0:SETS-1];

  logic [31:0]           m;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  word_sel;
  logic                  unused_addr_bits;

  assign m        = bus.address - 32'd1024;
  assign idx      = m[3 +: IDX_W];
  assign tag      = m[3+IDX_W +: TAG_W];
  assign word_sel = m[2];
  assign unused_addr_bits = ^{m[31:3+IDX_W+TAG_W], m[1:0]};

  logic hit0, hit1, hit, hit_way, victim;
  logic [31:0] hit_word;

  assign hit0     = valid_q[0][idx] && (tag_mem[0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_mem[1][idx] == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_word = data_mem[hit_way][idx][word_sel];
  // Victim stays stable across both fills: valid only changes at the end of FILL1.
  assign victim   = !valid_q[0][idx] ? 1'b0 :
                    !valid_q[1][idx] ? 1'b1 : lru_q[idx];

  logic        data_we;
  logic        data_way;
  logic        data_word;
  logic [31:0] data_wval;
  logic        tag_we;
  logic        ready_w;
  logic [31:0] rdata_w;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    lru_d      = lru_q;
    read_en_d  = read_en_q;
    write_en_d = write_en_q;
    data_we    = 1'b0;
    data_way   = 1'b0;
    data_word  = 1'b0;
    data_wval  = 32'd0;
    tag_we     = 1'b0;
    ready_w    = 1'b0;
    rdata_w    = 32'd0;

    case (state_q)
      IDLE: begin
        if (bus.MEM_W_EN) begin
          state_d    = WRITE;
          write_en_d = 1'b1;
          if (hit) begin
            data_we    = 1'b1;
            data_way   = hit_way;
            data_word  = word_sel;
            data_wval  = bus.wdata;
            lru_d[idx] = ~hit_way;
          end
        end else if (bus.MEM_R_EN) begin
          if (hit) begin
            ready_w    = 1'b1;
            rdata_w    = hit_word;
            lru_d[idx] = ~hit_way;
          end else begin
            state_d   = FILL0;
            read_en_d = 1'b1;
          end
        end else begin
          ready_w = 1'b1;
        end
      end
      FILL0: begin
        if (bus.sram_ready) begin
          data_we   = 1'b1;
          data_way  = victim;
          data_word = 1'b0;
          data_wval = bus.sram_rdata;
          state_d   = FILL1;
          read_en_d = 1'b1;
        end
      end
      FILL1: begin
        if (bus.sram_ready) begin
          data_we              = 1'b1;
          data_way             = victim;
          data_word            = 1'b1;
          data_wval            = bus.sram_rdata;
          tag_we               = 1'b1;
          valid_d[victim][idx] = 1'b1;
          lru_d[idx]           = ~victim;
          read_en_d            = 1'b0;
          state_d              = IDLE;
        end
      end
      WRITE: begin
        if (bus.sram_ready) begin
          write_en_d = 1'b0;
          state_d    = WDONE;
        end
      end
      WDONE: begin
        ready_w = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      lru_q      <= '0;
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      lru_q      <= lru_d;
      read_en_q  <= read_en_d;
      write_en_q <= write_en_d;
    end
  end

  // Storage arrays are deliberately not reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[data_way][idx][data_word] <= data_wval;
    end
    if (tag_we) begin
      tag_mem[victim][idx] <= tag;
    end
  end

  logic [31:0] sram_address_w;
  logic [31:0] sram_wdata_w;

  always_comb begin
    sram_address_w = 32'd0;
    sram_wdata_w   = 32'd0;
    case (state_q)
      FILL0: sram_address_w = {bus.address[31:3], 3'b000};
      FILL1: sram_address_w = {bus.address[31:3], 3'b100};
      WRITE: begin
        sram_address_w = bus.address;
        sram_wdata_w   = bus.wdata;
      end
      default: begin
        sram_address_w = 32'd0;
        sram_wdata_w   = 32'd0;
      end
    endcase
  end

  assign bus.ready         = ready_w;
  assign bus.rdata         = rdata_w;
  assign bus.sram_address  = sram_address_w;
  assign bus.sram_wdata    = sram_wdata_w;
  assign bus.sram_read_en  = read_en_q;
  assign bus.sram_write_en = write_en_q;

endmodule

`default_nettype wire
